eeprom_req_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single SPI EEPROM interface between NUM_REQ requesters (for example a boot-time codebook loader and a host register bridge).
- Holds command fields stable for the whole transaction.
- Issues a one-cycle addr_vld.
- Steers the wdata/rdata handshakes to the granted requester.
- Detects completion from the interface's busy flag, then returns a per-requester done pulse.
- Erase traffic (erase_ctrl toggle) bypasses this block. The arbiter only yields to it.

---
 rtl/eeprom_req_arbiter_pkg.sv | 21 ++
 rtl/eeprom_req_arbiter_if.sv | 31 +++
 rtl/eeprom_req_arbiter_rr.sv | 29 ++
 rtl/eeprom_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_eeprom_req_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_req_arbiter_pkg.sv
// Shared definitions for the EEPROM request arbiter: FSM state encoding and
// the width helper used to size grant indices.
package eeprom_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BSY,
        ST_XFER,
        ST_DONE
    } arb_state_e;

    // Index width for n requesters, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/eeprom_req_arbiter_if.sv
// Command/data bus between the arbiter (master) and the SPI EEPROM interface
// block (slave).
interface eeprom_req_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10
);
    logic [ADDR_W-1:0] ee_addr;
    logic              ee_addr_vld;
    logic              ee_wr_rd_sel;
    logic              ee_id_mem_sel;
    logic [LEN_W-1:0]  ee_data_len;
    logic [7:0]        ee_wdata;
    logic              ee_wdata_vld;
    logic              ee_wdata_rdy;
    logic [7:0]        ee_rdata;
    logic              ee_rdata_vld;
    logic              ee_rdata_rdy;
    logic              ee_busy;

    modport master (
        output ee_addr, ee_addr_vld, ee_wr_rd_sel, ee_id_mem_sel, ee_data_len,
               ee_wdata, ee_wdata_vld, ee_rdata_rdy,
        input  ee_wdata_rdy, ee_rdata, ee_rdata_vld, ee_busy
    );

    modport slave (
        input  ee_addr, ee_addr_vld, ee_wr_rd_sel, ee_id_mem_sel, ee_data_len,
               ee_wdata, ee_wdata_vld, ee_rdata_rdy,
        output ee_wdata_rdy, ee_rdata, ee_rdata_vld, ee_busy
    );
endinterface

// File: rtl/eeprom_req_arbiter_rr.sv
// Combinational round-robin pick: first set request bit at or above ptr,
// wrapping around NUM_REQ.
module rr_arbiter
    import eeprom_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      gnt,
    output logic               gnt_vld
);
    int idx;

    // Walk offsets from the far end so the nearest set bit is written last.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                gnt     = GW'(idx);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/eeprom_req_arbiter.sv
// Round-robin sequencer sharing one SPI EEPROM interface between NUM_REQ
// requesters. Optional watchdog: define EEP_ARB_TIMEOUT_EN.
module eeprom_req_arbiter
    import eeprom_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = 24,
    parameter  int LEN_W   = 10,
    parameter  int TMO_W   = 20,
    localparam int GW      = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ack,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ-1:0]        req_id,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*8-1:0]      req_wdata,
    input  logic [NUM_REQ-1:0]        req_wdata_vld,
    output logic [NUM_REQ-1:0]        req_wdata_rdy,
    output logic [7:0]                req_rdata,
    output logic [NUM_REQ-1:0]        req_rdata_vld,
    input  logic [NUM_REQ-1:0]        req_rdata_rdy,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    eeprom_req_arbiter_if.master      ee,
    output logic [GW-1:0]             grant_id,
    output logic                      arb_busy
);
    arb_state_e          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                id_q, id_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                addr_vld_q, addr_vld_d;
    logic [GW-1:0]       pick;
    logic                pick_vld;
    logic                xfer;

`ifdef EEP_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (pick),
        .gnt_vld (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        id_d       = id_q;
        len_d      = len_q;
        ack_d      = '0;
        addr_vld_d = 1'b0;
`ifdef EEP_ARB_TIMEOUT_EN
        err_d      = '0;
        tmo_d      = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A busy interface here means erase or foreign traffic owns it.
                if (!ee.ee_busy && pick_vld) begin
                    grant_d = pick;
                    addr_d  = req_addr[pick*ADDR_W +: ADDR_W];
                    wr_d    = req_wr[pick];
                    id_d    = req_id[pick];
                    len_d   = req_len[pick*LEN_W +: LEN_W];
                    ack_d   = NUM_REQ'(1) << pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Zero-length requests complete without touching the interface.
                if (len_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    addr_vld_d = 1'b1;
                    state_d    = ST_WAIT_BSY;
                end
            end
            ST_WAIT_BSY: if (ee.ee_busy)  state_d = ST_XFER;
            ST_XFER:     if (!ee.ee_busy) state_d = ST_DONE;
            ST_DONE: begin
                rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef EEP_ARB_TIMEOUT_EN
        if ((state_q == ST_WAIT_BSY || state_q == ST_XFER) && (&tmo_q)) begin
            err_d   = NUM_REQ'(1) << grant_q;
            state_d = ST_IDLE;
        end
        if (state_q == ST_WAIT_BSY || state_q == ST_XFER) tmo_d = tmo_q + TMO_W'(1);
        if (state_d != state_q && (state_d == ST_WAIT_BSY || state_d == ST_XFER)) tmo_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            id_q       <= 1'b0;
            len_q      <= '0;
            ack_q      <= '0;
            addr_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            ack_q      <= ack_d;
            addr_vld_q <= addr_vld_d;
        end
    end

`ifdef EEP_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign req_err = err_q;
`else
    assign req_err = '0;
`endif

    assign xfer     = (state_q == ST_XFER);
    assign req_ack  = ack_q;
    assign grant_id = grant_q;
    assign arb_busy = (state_q != ST_IDLE);

    assign ee.ee_addr       = addr_q;
    assign ee.ee_addr_vld   = addr_vld_q;
    assign ee.ee_wr_rd_sel  = wr_q;
    assign ee.ee_id_mem_sel = id_q;
    assign ee.ee_data_len   = len_q;
    assign ee.ee_wdata      = xfer ? req_wdata[grant_q*8 +: 8] : 8'h00;
    assign ee.ee_wdata_vld  = xfer && req_wdata_vld[grant_q];
    assign ee.ee_rdata_rdy  = xfer && req_rdata_rdy[grant_q];
    assign req_rdata        = xfer ? ee.ee_rdata : 8'h00;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_steer
        assign req_wdata_rdy[gi] = xfer && (grant_q == GW'(gi)) && ee.ee_wdata_rdy;
        assign req_rdata_vld[gi] = xfer && (grant_q == GW'(gi)) && ee.ee_rdata_vld;
        assign req_done[gi]      = (state_q == ST_DONE) && (grant_q == GW'(gi));
    end
endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Bench for eeprom_req_arbiter: table of single transactions plus hand-written
// arbitration, busy-gate, reset and (with EEP_ARB_TIMEOUT_EN) watchdog sequences.
`timescale 1ns/1ps
module tb_eeprom_req_arbiter;
    localparam int NR = 2;
    localparam int AW = 24;
    localparam int LW = 10;
    localparam int TW = 6;

    typedef struct {
        int          r;
        logic        wr;
        logic        id;
        logic [23:0] addr;
        logic [9:0]  len;
        logic [23:0] wb;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ack, req_wr, req_id, req_wdata_vld, req_wdata_rdy;
    logic [NR-1:0]    req_rdata_vld, req_rdata_rdy, req_done, req_err;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR*8-1:0]  req_wdata;
    logic [7:0]       req_rdata;
    logic [0:0]       grant_id;
    logic             arb_busy;

    eeprom_req_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) ee_if ();

    eeprom_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TMO_W(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ack       (req_ack),
        .req_addr      (req_addr),
        .req_wr        (req_wr),
        .req_id        (req_id),
        .req_len       (req_len),
        .req_wdata     (req_wdata),
        .req_wdata_vld (req_wdata_vld),
        .req_wdata_rdy (req_wdata_rdy),
        .req_rdata     (req_rdata),
        .req_rdata_vld (req_rdata_vld),
        .req_rdata_rdy (req_rdata_rdy),
        .req_done      (req_done),
        .req_err       (req_err),
        .ee            (ee_if),
        .grant_id      (grant_id),
        .arb_busy      (arb_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    // EEPROM interface model: busy two cycles after addr_vld, then moves data_len bytes.
    logic          m_dly, m_busy, m_wr, force_busy;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_left;
    logic [7:0]    m_idx;
    assign ee_if.ee_busy      = m_busy | force_busy;
    assign ee_if.ee_rdata_vld = m_busy && !m_wr && (m_left != '0);
    assign ee_if.ee_wdata_rdy = m_busy && m_wr && (m_left != '0);
    assign ee_if.ee_rdata     = mem_byte(m_addr + AW'(m_idx));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dly <= 1'b0; m_busy <= 1'b0; m_wr <= 1'b0;
            m_addr <= '0; m_left <= '0; m_idx <= '0;
        end else begin
            m_dly <= ee_if.ee_addr_vld;
            if (ee_if.ee_addr_vld) begin
                m_addr <= ee_if.ee_addr; m_wr <= ee_if.ee_wr_rd_sel;
                m_left <= ee_if.ee_data_len; m_idx <= '0;
            end
            if (m_dly) m_busy <= 1'b1;
            else if (m_busy) begin
                if (m_left == '0) m_busy <= 1'b0;
                else if ((m_wr && ee_if.ee_wdata_vld && ee_if.ee_wdata_rdy) ||
                         (!m_wr && ee_if.ee_rdata_vld && ee_if.ee_rdata_rdy)) begin
                    m_left <= m_left - 1'b1;
                    m_idx  <= m_idx + 8'd1;
                end
            end
        end
    end

    // Requester side: write byte sources and alternating read backpressure.
    logic [23:0] wsrc_b[NR] = '{default: 24'h0};
    int          wlen[NR]   = '{default: 0};
    int          widx[NR]   = '{default: 0};
    logic        tgl = 1'b0;
    always @(posedge clk) tgl <= ~tgl;
    assign req_rdata_rdy = {~tgl, tgl};

    always @(posedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (req_ack[r]) widx[r] <= 0;
            else if (req_wdata_vld[r] && req_wdata_rdy[r]) widx[r] <= widx[r] + 1;
        end
    end

    always_comb begin
        req_wdata     = '0;
        req_wdata_vld = '0;
        for (int r = 0; r < NR; r++) begin
            if (widx[r] < 3) req_wdata[r*8 +: 8] = 8'(wsrc_b[r] >> (16 - 8 * widx[r]));
            req_wdata_vld[r] = (widx[r] < wlen[r]);
        end
    end

    // Monitor: scoreboard pops, steering, busy overlap and addr_vld spacing.
    int cycnt = 0;
    int av_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = -100;
    always @(posedge clk) cycnt <= cycnt + 1;

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (rst_n) begin
            if (ee_if.ee_addr_vld) begin
                av_cnt++;
                check("addr_vld_while_busy", ee_if.ee_busy, 1'b0);
                check("addr_vld_gap_ge3", (cycnt - last_done_cyc) >= 3, 1);
            end
            for (int r = 0; r < NR; r++) begin
                if (req_rdata_vld[r] && req_rdata_rdy[r]) begin
                    check("rd_steer", r, grant_id);
                    check("rd_q_nonempty", rd_q.size() != 0, 1);
                    if (rd_q.size() != 0) begin
                        e = rd_q.pop_front();
                        check("rdata", req_rdata, e);
                    end
                end
            end
            if (ee_if.ee_wdata_vld && ee_if.ee_wdata_rdy) begin
                check("wr_rdy_route", req_wdata_rdy, 32'(1) << grant_id);
                check("wr_q_nonempty", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    check("wdata", ee_if.ee_wdata, e);
                end
            end
            if (req_done != '0) begin
                done_cnt++;
                last_done_cyc = cycnt;
            end
            err_cnt += $countones(req_err);
        end
    end

    // which: 0 ack[r], 1 done[r], 2 err[r], 3 any ack. cyc = negedges waited.
    task automatic wait_evt(input int which, input int r, input int limit,
                            output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            cyc++;
            case (which)
                0: seen = req_ack[r];
                1: seen = req_done[r];
                2: seen = req_err[r];
                default: seen = (req_ack != '0);
            endcase
        end
    endtask

    task automatic set_req(input txn_t t);
        req_addr[t.r*AW +: AW] = t.addr;
        req_len[t.r*LW +: LW]  = t.len;
        req_wr[t.r]            = t.wr;
        req_id[t.r]            = t.id;
        wsrc_b[t.r]            = t.wb;
        wlen[t.r]              = t.wr ? int'(t.len) : 0;
    endtask

    task automatic push_exp(input txn_t t);
        for (int i = 0; i < int'(t.len); i++) begin
            if (t.wr) wr_q.push_back(8'(t.wb >> (16 - 8 * i)));
            else      rd_q.push_back(mem_byte(t.addr + 24'(i)));
        end
    endtask

    task automatic run_txn(input txn_t t);
        int cyc;
        bit seen;
        int av0;
        @(negedge clk);
        set_req(t);
        push_exp(t);
        av0 = av_cnt;
        req_valid[t.r] = 1'b1;
        wait_evt(0, t.r, 50, cyc, seen);
        check("ack_seen", seen, 1);
        check("ack_latency", cyc, 1);
        check("grant_id", grant_id, t.r);
        req_valid[t.r] = 1'b0;
        req_addr[t.r*AW +: AW] = ~t.addr;
        req_len[t.r*LW +: LW]  = ~t.len;
        req_wr[t.r] = ~t.wr;
        req_id[t.r] = ~t.id;
        wait_evt(1, t.r, 200, cyc, seen);
        check("done_seen", seen, 1);
        if (t.len == '0) check("len0_done_latency", cyc, 1);
        check("ee_addr_held", ee_if.ee_addr, t.addr);
        check("ee_wr_held", ee_if.ee_wr_rd_sel, t.wr);
        check("ee_id_held", ee_if.ee_id_mem_sel, t.id);
        check("ee_len_held", ee_if.ee_data_len, t.len);
        check("addr_vld_count", av_cnt - av0, (t.len != '0) ? 1 : 0);
        check("sb_drained", rd_q.size() + wr_q.size(), 0);
        wlen[t.r] = 0;
        $display("txn r%0d wr=%0d addr=%06h len=%0d done", t.r, t.wr, t.addr, t.len);
    endtask

    txn_t tbl[5];
    int   rem[NR];

    initial begin
        int   cyc;
        bit   seen;
        int   g;
        int   exp_g;
        txn_t t;

        tbl[0] = '{r: 0, wr: 1'b0, id: 1'b0, addr: 24'h000100, len: 10'd4, wb: 24'h0};
        tbl[1] = '{r: 1, wr: 1'b1, id: 1'b0, addr: 24'h001000, len: 10'd3, wb: 24'hA55AC3};
        tbl[2] = '{r: 0, wr: 1'b0, id: 1'b0, addr: 24'h000777, len: 10'd0, wb: 24'h0};
        tbl[3] = '{r: 1, wr: 1'b0, id: 1'b1, addr: 24'h000020, len: 10'd2, wb: 24'h0};
        tbl[4] = '{r: 0, wr: 1'b1, id: 1'b1, addr: 24'h0000F0, len: 10'd1, wb: 24'h3C0000};

        req_valid = '0; req_addr = '0; req_len = '0; req_wr = '0; req_id = '0;
        force_busy = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ack", req_ack, 0);
        check("rst_addr_vld", ee_if.ee_addr_vld, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_ee_addr", ee_if.ee_addr, 0);
        check("rst_done", req_done, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_txn(tbl[i]);

        // Busy held in IDLE (erase): no grant until it drops, then one cycle.
        t = '{r: 0, wr: 1'b0, id: 1'b0, addr: 24'h000400, len: 10'd1, wb: 24'h0};
        @(negedge clk);
        force_busy = 1'b1;
        set_req(t);
        push_exp(t);
        req_valid[0] = 1'b1;
        wait_evt(0, 0, 6, cyc, seen);
        check("no_ack_while_busy", seen, 0);
        force_busy = 1'b0;
        wait_evt(0, 0, 50, cyc, seen);
        check("ack_after_busy", seen, 1);
        check("ack_after_busy_latency", cyc, 1);
        req_valid[0] = 1'b0;
        wait_evt(1, 0, 200, cyc, seen);
        check("busy_gate_done", seen, 1);
        check("busy_gate_sb", rd_q.size(), 0);
        $display("txn busy-gated r0 done");

        // Reset in the middle of a read.
        t = '{r: 1, wr: 1'b0, id: 1'b0, addr: 24'h000500, len: 10'd3, wb: 24'h0};
        @(negedge clk);
        set_req(t);
        req_valid[1] = 1'b1;
        wait_evt(0, 1, 50, cyc, seen);
        check("midrst_ack", seen, 1);
        req_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_arb_busy", arb_busy, 0);
        check("midrst_ee_addr", ee_if.ee_addr, 0);
        check("midrst_rdata_vld", req_rdata_vld, 0);
        rd_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset mid-read done");

        // Both requesters pending: grants must alternate 0,1,0,1.
        t = '{r: 0, wr: 1'b0, id: 1'b0, addr: 24'h000200, len: 10'd2, wb: 24'h0};
        set_req(t);
        t = '{r: 1, wr: 1'b0, id: 1'b0, addr: 24'h000300, len: 10'd2, wb: 24'h0};
        set_req(t);
        rem[0] = 2;
        rem[1] = 2;
        exp_g  = 0;
        @(negedge clk);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_evt(3, 0, 50, cyc, seen);
            check("rr_ack_seen", seen, 1);
            check("rr_ack_order", req_ack, 32'(1) << exp_g);
            g = int'(grant_id);
            t = '{r: g, wr: 1'b0, id: 1'b0, addr: (g == 0) ? 24'h000200 : 24'h000300,
                  len: 10'd2, wb: 24'h0};
            push_exp(t);
            req_valid[g] = 1'b0;
            wait_evt(1, g, 200, cyc, seen);
            check("rr_done_seen", seen, 1);
            rem[g]--;
            if (rem[g] > 0) req_valid[g] = 1'b1;
            $display("rr txn %0d granted r%0d", k, g);
            exp_g = 1 - exp_g;
        end
        check("rr_sb_drained", rd_q.size(), 0);

`ifdef EEP_ARB_TIMEOUT_EN
        // Busy stuck high: watchdog fires 2 + 2**TW cycles after the ack.
        begin
            int d0;
            t = '{r: 1, wr: 1'b0, id: 1'b0, addr: 24'h000040, len: 10'd1, wb: 24'h0};
            @(negedge clk);
            set_req(t);
            push_exp(t);
            d0 = done_cnt;
            req_valid[1] = 1'b1;
            wait_evt(0, 1, 50, cyc, seen);
            check("tmo_ack", seen, 1);
            req_valid[1] = 1'b0;
            @(negedge clk);
            force_busy = 1'b1;
            wait_evt(2, 1, 200, cyc, seen);
            check("tmo_err_seen", seen, 1);
            check("tmo_err_latency", cyc + 1, 2 + (1 << TW));
            check("tmo_idle", arb_busy, 0);
            check("tmo_no_done", done_cnt - d0, 0);
            @(negedge clk);
            force_busy = 1'b0;
            check("tmo_err_count", err_cnt, 1);
            $display("txn watchdog r1 err");
        end
`else
        check("err_tied_zero", err_cnt, 0);
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end
endmodule
